// File: rtl/inst_fifo_dual_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo_dual_pkg
// Description : Shared types and slot-count helpers for the dual-issue
//               instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fifo_dual_pkg;

    localparam int C_DEF_DEPTH  = 16;
    localparam int C_DEF_PC_W   = 32;
    localparam int C_DEF_INST_W = 32;

    typedef logic [1:0] cnt2_t;

    // Number of accepted fetch slots; 2'b10 breaks the in-order rule and is dropped.
    function automatic cnt2_t f_npush(input logic [1:0] valid);
        cnt2_t n;
        n = 2'd0;
        case (valid)
            2'b01:   n = 2'd1;
            2'b11:   n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Number of entries actually retired; a pop of an empty slot is ignored.
    function automatic cnt2_t f_npop(input logic [1:0] pop,
                                     input logic       valid0,
                                     input logic       valid1);
        cnt2_t n;
        n = 2'd0;
        case (pop)
            2'b01:   n = valid0 ? 2'd1 : 2'd0;
            2'b11:   n = valid1 ? 2'd2 : (valid0 ? 2'd1 : 2'd0);
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo_ram
// Description : DEPTH x W storage array, two adjacent write ports and two
//               asynchronous read ports. No reset on the array.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 65
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [W-1:0]             wdata0,
    input  logic [W-1:0]             wdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr0,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    output logic [W-1:0]             rdata0,
    output logic [W-1:0]             rdata1
);

    logic [W-1:0] r_mem [DEPTH];

    // Write addresses are always distinct (wptr and wptr+1), so no port conflict.
    always_ff @(posedge clk) begin
        if (we0) r_mem[waddr0] <= wdata0;
        if (we1) r_mem[waddr1] <= wdata1;
    end

    assign rdata0 = r_mem[raddr0];
    assign rdata1 = r_mem[raddr1];

endmodule
`default_nettype wire

// File: rtl/inst_fifo_dual.sv
`default_nettype none
// ============================================================================
// Module      : inst_fifo_dual
// Description : Dual-issue instruction buffer between IF and the two ID
//               decoders, with redirect flush and delay-slot retention.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo_dual
    import inst_fifo_dual_pkg::*;
#(
    parameter int DEPTH  = C_DEF_DEPTH,
    parameter int PC_W   = C_DEF_PC_W,
    parameter int INST_W = C_DEF_INST_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   flush_keep_ds,
    input  logic [1:0]             in_valid,
    input  logic [PC_W-1:0]        in_pc0,
    input  logic [PC_W-1:0]        in_pc1,
    input  logic [INST_W-1:0]      in_inst0,
    input  logic [INST_W-1:0]      in_inst1,
    input  logic                   in_adel0,
    input  logic                   in_adel1,
    output logic                   full,
    output logic                   out_valid0,
    output logic                   out_valid1,
    output logic [PC_W-1:0]        out_pc0,
    output logic [PC_W-1:0]        out_pc1,
    output logic [INST_W-1:0]      out_inst0,
    output logic [INST_W-1:0]      out_inst1,
    output logic                   out_adel0,
    output logic                   out_adel1,
    input  logic [1:0]             out_pop,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_ew = PC_W + INST_W + 1;

    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;

    logic            w_full;
    logic            w_valid0;
    logic            w_valid1;
    logic            w_keep;
    cnt2_t           w_npush;
    cnt2_t           w_npop;
    logic [c_ew-1:0] w_wdata0;
    logic [c_ew-1:0] w_wdata1;
    logic [c_ew-1:0] w_rdata0;
    logic [c_ew-1:0] w_rdata1;

    assign w_full   = (r_count > c_cw'(DEPTH - 2));
    assign w_valid0 = (r_count != '0);
    assign w_valid1 = (r_count >= c_cw'(2));

    // A flush swallows both sides of the handshake; a full buffer refuses the push
    // even when a pop frees room in the same cycle.
    assign w_npush = (flush || w_full) ? 2'd0 : f_npush(in_valid);
    assign w_npop  = flush ? 2'd0 : f_npop(out_pop, w_valid0, w_valid1);

    // The delay slot survives only if it is buffered and was not issued this cycle.
    assign w_keep = flush_keep_ds && w_valid0 && !out_pop[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= w_keep ? (r_rptr + c_aw'(1)) : r_rptr;
            r_count <= w_keep ? c_cw'(1) : '0;
        end else begin
            r_rptr  <= r_rptr + c_aw'(w_npop);
            r_wptr  <= r_wptr + c_aw'(w_npush);
            r_count <= r_count + c_cw'(w_npush) - c_cw'(w_npop);
        end
    end

    assign w_wdata0 = {in_adel0, in_pc0, in_inst0};
    assign w_wdata1 = {in_adel1, in_pc1, in_inst1};

    inst_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (c_ew)
    ) u_ram (
        .clk    (clk),
        .we0    (w_npush != 2'd0),
        .we1    (w_npush == 2'd2),
        .waddr0 (r_wptr),
        .waddr1 (r_wptr + c_aw'(1)),
        .wdata0 (w_wdata0),
        .wdata1 (w_wdata1),
        .raddr0 (r_rptr),
        .raddr1 (r_rptr + c_aw'(1)),
        .rdata0 (w_rdata0),
        .rdata1 (w_rdata1)
    );

    assign full       = w_full;
    assign count      = r_count;
    assign out_valid0 = w_valid0;
    assign out_valid1 = w_valid1;

    assign out_adel0 = w_valid0 ? w_rdata0[c_ew-1]           : 1'b0;
    assign out_pc0   = w_valid0 ? w_rdata0[c_ew-2 -: PC_W]   : '0;
    assign out_inst0 = w_valid0 ? w_rdata0[INST_W-1:0]       : '0;
    assign out_adel1 = w_valid1 ? w_rdata1[c_ew-1]           : 1'b0;
    assign out_pc1   = w_valid1 ? w_rdata1[c_ew-2 -: PC_W]   : '0;
    assign out_inst1 = w_valid1 ? w_rdata1[INST_W-1:0]       : '0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fifo_dual.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fifo_dual
// Description : Self-checking bench for inst_fifo_dual: directed vector table,
//               queue scoreboard, random push/pop/flush and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fifo_dual;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          flush_keep_ds;
    logic [1:0]    in_valid;
    logic [31:0]   in_pc0, in_pc1, in_inst0, in_inst1;
    logic          in_adel0, in_adel1;
    logic          full, out_valid0, out_valid1;
    logic [31:0]   out_pc0, out_pc1, out_inst0, out_inst1;
    logic          out_adel0, out_adel1;
    logic [1:0]    out_pop;
    logic [CW-1:0] count;

    inst_fifo_dual #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .flush_keep_ds (flush_keep_ds),
        .in_valid      (in_valid),
        .in_pc0        (in_pc0),
        .in_pc1        (in_pc1),
        .in_inst0      (in_inst0),
        .in_inst1      (in_inst1),
        .in_adel0      (in_adel0),
        .in_adel1      (in_adel1),
        .full          (full),
        .out_valid0    (out_valid0),
        .out_valid1    (out_valid1),
        .out_pc0       (out_pc0),
        .out_pc1       (out_pc1),
        .out_inst0     (out_inst0),
        .out_inst1     (out_inst1),
        .out_adel0     (out_adel0),
        .out_adel1     (out_adel1),
        .out_pop       (out_pop),
        .count         (count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] q[$];

    typedef struct {
        logic [1:0]  v;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  pop;
        logic        fl;
        logic        keep;
        int          ecnt;
        logic [31:0] epc0;
        logic        efull;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] f_inst(input logic [31:0] pc);
        return ~pc ^ 32'h0F0F_1234;
    endfunction

    function automatic logic f_adel(input logic [31:0] pc);
        return ^pc[5:2];
    endfunction

    function automatic vec_t mk(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                                input logic [1:0] pop, input logic fl, input logic keep,
                                input int ecnt, input logic [31:0] epc0, input logic efull);
        vec_t r;
        r.v = v; r.pc0 = pc0; r.pc1 = pc1; r.pop = pop; r.fl = fl; r.keep = keep;
        r.ecnt = ecnt; r.epc0 = epc0; r.efull = efull;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = q.size();
        chk({tag, ":count"},  64'(count),      64'(n));
        chk({tag, ":full"},   64'(full),       64'(n > DEPTH - 2));
        chk({tag, ":valid0"}, 64'(out_valid0), 64'(n >= 1));
        chk({tag, ":valid1"}, 64'(out_valid1), 64'(n >= 2));
        chk({tag, ":pc0"},    64'(out_pc0),    64'(n >= 1 ? q[0] : 32'd0));
        chk({tag, ":inst0"},  64'(out_inst0),  64'(n >= 1 ? f_inst(q[0]) : 32'd0));
        chk({tag, ":adel0"},  64'(out_adel0),  64'(n >= 1 ? f_adel(q[0]) : 1'b0));
        chk({tag, ":pc1"},    64'(out_pc1),    64'(n >= 2 ? q[1] : 32'd0));
        chk({tag, ":inst1"},  64'(out_inst1),  64'(n >= 2 ? f_inst(q[1]) : 32'd0));
        chk({tag, ":adel1"},  64'(out_adel1),  64'(n >= 2 ? f_adel(q[1]) : 1'b0));
    endtask

    // Called just after an active edge: drive, score issued entries, update the model, clock, check.
    task automatic cycle(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] pop, input logic fl, input logic keep, input string tag);
        int          n;
        int          np;
        logic [31:0] e;
        in_valid = v; in_pc0 = pc0; in_pc1 = pc1;
        in_inst0 = f_inst(pc0); in_inst1 = f_inst(pc1);
        in_adel0 = f_adel(pc0); in_adel1 = f_adel(pc1);
        out_pop = pop; flush = fl; flush_keep_ds = keep;
        #1;
        n = q.size();
        if (fl) begin
            if (keep && n >= 1 && !pop[0]) begin
                e = q[0];
                q.delete();
                q.push_back(e);
            end else begin
                if (pop[0] && n >= 1) chk({tag, ":ds_issue_pc"}, 64'(out_pc0), 64'(q[0]));
                q.delete();
            end
        end else begin
            np = (pop == 2'b01) ? 1 : (pop == 2'b11) ? 2 : 0;
            if (np > n) np = n;
            for (int i = 0; i < np; i++) begin
                e = q.pop_front();
                chk({tag, ":issue_pc"},   64'(i == 0 ? out_pc0 : out_pc1),     64'(e));
                chk({tag, ":issue_inst"}, 64'(i == 0 ? out_inst0 : out_inst1), 64'(f_inst(e)));
            end
            if (n <= DEPTH - 2) begin
                if (v[0])       q.push_back(pc0);
                if (v == 2'b11) q.push_back(pc1);
            end
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    logic [31:0] B;
    logic [31:0] rpc;

    initial begin
        B = 32'hBFC0_0000;
        resetn = 1'b0; flush = 1'b0; flush_keep_ds = 1'b0; in_valid = 2'b00; out_pop = 2'b00;
        in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0; in_adel0 = 1'b0; in_adel1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check_state("reset");

        tbl.push_back(mk(2'b11, B,        B+32'h04, 2'b00, 0, 0, 2,  B, 0));
        tbl.push_back(mk(2'b11, B+32'h08, B+32'h0C, 2'b00, 0, 0, 4,  B, 0));
        tbl.push_back(mk(2'b11, B+32'h10, B+32'h14, 2'b00, 0, 0, 6,  B, 0));
        tbl.push_back(mk(2'b11, B+32'h18, B+32'h1C, 2'b00, 0, 0, 8,  B, 0));
        tbl.push_back(mk(2'b11, B+32'h20, B+32'h24, 2'b00, 0, 0, 10, B, 0));
        tbl.push_back(mk(2'b11, B+32'h28, B+32'h2C, 2'b00, 0, 0, 12, B, 0));
        tbl.push_back(mk(2'b11, B+32'h30, B+32'h34, 2'b00, 0, 0, 14, B, 0));
        tbl.push_back(mk(2'b01, B+32'h38, 32'h0,    2'b00, 0, 0, 15, B, 1));
        tbl.push_back(mk(2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 2'b00, 0, 0, 15, B, 1));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 13, B+32'h08, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b10, 0, 0, 13, B+32'h08, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 11, B+32'h10, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 9,  B+32'h18, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 7,  B+32'h20, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 5,  B+32'h28, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 3,  B+32'h30, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b01, 0, 0, 2,  B+32'h34, 0));
        tbl.push_back(mk(2'b11, 32'h1000_0000, 32'h1000_0004, 2'b11, 0, 0, 2, 32'h1000_0000, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 0, 32'h0, 0));
        tbl.push_back(mk(2'b11, 32'h8000_0010, 32'h8000_0014, 2'b00, 0, 0, 2, 32'h8000_0010, 0));
        tbl.push_back(mk(2'b11, 32'h8000_0018, 32'h8000_001C, 2'b00, 0, 0, 4, 32'h8000_0010, 0));
        tbl.push_back(mk(2'b01, 32'h8000_0020, 32'h0,         2'b00, 0, 0, 5, 32'h8000_0010, 0));
        tbl.push_back(mk(2'b11, 32'h9000_0000, 32'h9000_0004, 2'b00, 1, 1, 1, 32'h8000_0010, 0));
        tbl.push_back(mk(2'b11, 32'h8000_0024, 32'h8000_0028, 2'b00, 0, 0, 3, 32'h8000_0010, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b01, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk(2'b11, 32'hA000_0000, 32'hA000_0004, 2'b00, 0, 0, 2, 32'hA000_0000, 0));
        tbl.push_back(mk(2'b11, 32'hB000_0000, 32'hB000_0004, 2'b00, 1, 0, 0, 32'h0, 0));
        tbl.push_back(mk(2'b11, 32'hB100_0000, 32'hB100_0004, 2'b00, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk(2'b11, 32'hC000_0000, 32'hC000_0004, 2'b01, 0, 0, 2, 32'hC000_0000, 0));
        tbl.push_back(mk(2'b00, 0, 0, 2'b11, 0, 0, 0, 32'h0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].pop, tbl[i].fl, tbl[i].keep, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d:tbl_count", i), 64'(count),   64'(tbl[i].ecnt));
            chk($sformatf("vec%0d:tbl_pc0", i),   64'(out_pc0), 64'(tbl[i].epc0));
            chk($sformatf("vec%0d:tbl_full", i),  64'(full),    64'(tbl[i].efull));
        end

        // Random traffic well past one lap of the pointers.
        rpc = 32'h0040_0000;
        for (int k = 0; k < 40; k++) begin
            logic [1:0] v;
            logic [1:0] p;
            logic       f;
            int         r;
            r = int'($urandom_range(0, 2));
            v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            r = int'($urandom_range(0, 2));
            p = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            f = ($urandom_range(0, 15) == 0);
            cycle(v, rpc, rpc + 32'd4, p, f, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d:count_bound", k), 64'(count <= CW'(DEPTH)), 64'(1));
            rpc = rpc + 32'd8;
        end

        // Asynchronous reset asserted in the middle of a clock period.
        cycle(2'b11, 32'hE000_0000, 32'hE000_0004, 2'b00, 0, 0, "pre_rst");
        in_valid = 2'b11; in_pc0 = 32'hE000_0008; in_pc1 = 32'hE000_000C;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst:valid0", 64'(out_valid0), 64'(0));
        chk("async_rst:valid1", 64'(out_valid1), 64'(0));
        chk("async_rst:count",  64'(count),      64'(0));
        chk("async_rst:full",   64'(full),       64'(0));
        q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle(2'b00, 0, 0, 2'b00, 0, 0, "post_rst");
        cycle(2'b11, 32'hF000_0000, 32'hF000_0004, 2'b00, 0, 0, "post_rst_push");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
